// File: rtl/sha2_sched_ctrl_if.sv
// Bus between a SHA-2 block source and the round controller.
//
// Handshake: start is the request and ready is the acceptance window. A block
// transfers on the rising clock edge where start=1 and ready=1; mode_512,
// first_block and msg_in are sampled on that same edge only. start seen while
// ready=0 is dropped, not queued. abort is a level-sensitive cancel that acts
// on the next edge whenever the controller is not idle.
interface sha2_sched_ctrl_if #(
  parameter int WORD_W = 64
);
  logic                  start;
  logic                  mode_512;
  logic                  first_block;
  logic                  abort;
  logic [16*WORD_W-1:0]  msg_in;

  logic                  ready;
  logic                  busy;
  logic                  load_state;
  logic                  sel_iv;
  logic                  round_valid;
  logic [6:0]            round_idx;
  logic [WORD_W-1:0]     w_out;
  logic                  final_add;
  logic                  done;
  logic [2:0]            dbg_state;

  modport master (
    output start, mode_512, first_block, abort, msg_in,
    input  ready, busy, load_state, sel_iv, round_valid, round_idx, w_out,
           final_add, done, dbg_state
  );

  modport slave (
    input  start, mode_512, first_block, abort, msg_in,
    output ready, busy, load_state, sel_iv, round_valid, round_idx, w_out,
           final_add, done, dbg_state
  );
endinterface

// File: rtl/sha2_sched_ctrl.sv
// SHA-2 round controller with an in-line message-schedule generator.
// Sequences IDLE -> LOAD -> ROUND -> FINAL -> DONE for one block and streams
// W_t / t each ROUND cycle; SHA-256 or SHA-512 is chosen per block.
module sha2_sched_ctrl #(
  parameter int WORD_W = 64
) (
  input logic              clk,
  input logic              rst,
  sha2_sched_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0]        LAST_256 = 7'd63;
  localparam logic [6:0]        LAST_512 = 7'd79;
  localparam logic [WORD_W-1:0] MASK_32  = WORD_W'(64'h0000_0000_FFFF_FFFF);

  state_t            state_q;
  state_t            state_d;
  logic [6:0]        t_q;
  logic              mode_q;
  logic              first_q;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] load_word [16];
  logic [WORD_W-1:0] new_word;
  logic              accept;
  logic              mode_in;
  logic [6:0]        last_t;
  logic [63:0]       w0_x, w1_x, w9_x, w14_x;
  logic [31:0]       sum_256;
  logic [63:0]       sum_512;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  // A 32-bit build has no SHA-512 datapath, so the mode request is tied off.
  assign mode_in = (WORD_W == 64) ? bus.mode_512 : 1'b0;
  assign accept  = (state_q == S_IDLE) && bus.start;
  assign last_t  = mode_q ? LAST_512 : LAST_256;

  // Slice the block into M0..M15; SHA-256 keeps only the low 32 bits per word.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      load_word[i] = mode_in ? bus.msg_in[(16-i)*WORD_W-1 -: WORD_W]
                             : (bus.msg_in[(16-i)*WORD_W-1 -: WORD_W] & MASK_32);
    end
  end

  // Next schedule word W_{t+16} from the current window taps.
  always_comb begin
    w0_x     = 64'(win_q[0]);
    w1_x     = 64'(win_q[1]);
    w9_x     = 64'(win_q[9]);
    w14_x    = 64'(win_q[14]);
    sum_256  = sig1_256(w14_x[31:0]) + w9_x[31:0] + sig0_256(w1_x[31:0]) + w0_x[31:0];
    sum_512  = sig1_512(w14_x) + w9_x + sig0_512(w1_x) + w0_x;
    new_word = mode_q ? WORD_W'(sum_512) : WORD_W'(sum_256);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over every non-idle transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = bus.abort ? S_IDLE : S_ROUND;
      S_ROUND: begin
        if (bus.abort)          state_d = S_IDLE;
        else if (t_q == last_t) state_d = S_FINAL;
      end
      S_FINAL: state_d = bus.abort ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Block capture on accept; round counter and window advance only in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= 7'd0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (accept) begin
      t_q     <= 7'd0;
      mode_q  <= mode_in;
      first_q <= bus.first_block;
      for (int i = 0; i < 16; i++) win_q[i] <= load_word[i];
    end else if (state_q == S_ROUND) begin
      t_q <= t_q + 7'd1;
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= new_word;
    end
  end

  // Moore output decode from state, round counter and window head.
  always_comb begin
    bus.ready       = (state_q == S_IDLE);
    bus.busy        = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);
    bus.load_state  = (state_q == S_LOAD);
    bus.sel_iv      = (state_q == S_LOAD) && first_q;
    bus.round_valid = (state_q == S_ROUND);
    bus.round_idx   = (state_q == S_ROUND) ? t_q : 7'd0;
    bus.w_out       = (state_q == S_ROUND) ? win_q[0] : '0;
    bus.final_add   = (state_q == S_FINAL);
    bus.done        = (state_q == S_DONE);
    bus.dbg_state   = state_q;
  end

endmodule

// File: tb/tb_sha2_sched_ctrl.sv
// Bench for sha2_sched_ctrl: a 64-bit and a 32-bit instance driven with the
// same stimulus, each checked every cycle against a cycle-offset model.
module tb_sha2_sched_ctrl;

  typedef logic [63:0] sched_t [80];

  localparam int B_READY = 13;
  localparam int B_BUSY  = 12;
  localparam int B_LOAD  = 11;
  localparam int B_SEL   = 10;
  localparam int B_RV    = 9;
  localparam int B_FINAL = 8;
  localparam int B_DONE  = 7;
  localparam logic [13:0] RESET_CTRL = 14'b10_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode_512 = 1'b0;
  logic          first_block = 1'b0;
  logic          abort = 1'b0;
  logic [1023:0] msg = '0;
  logic [511:0]  msg32;

  int checks = 0;
  int errors = 0;
  int off = 0;

  sha2_sched_ctrl_if #(.WORD_W(64)) if64 ();
  sha2_sched_ctrl_if #(.WORD_W(32)) if32 ();

  sha2_sched_ctrl #(.WORD_W(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
  sha2_sched_ctrl #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // The 32-bit instance receives the low half of each 64-bit message word.
  always_comb begin
    for (int k = 0; k < 16; k++) msg32[(16-k)*32-1 -: 32] = msg[(16-k)*64-33 -: 32];
  end

  assign if64.start = start;       assign if32.start = start;
  assign if64.mode_512 = mode_512; assign if32.mode_512 = mode_512;
  assign if64.first_block = first_block; assign if32.first_block = first_block;
  assign if64.abort = abort;       assign if32.abort = abort;
  assign if64.msg_in = msg;        assign if32.msg_in = msg32;

  logic [13:0] a_ctrl [2];
  logic [63:0] a_w    [2];
  logic [2:0]  a_st   [2];

  always_comb begin
    a_ctrl[0] = {if64.ready, if64.busy, if64.load_state, if64.sel_iv, if64.round_valid,
                 if64.final_add, if64.done, if64.round_idx};
    a_ctrl[1] = {if32.ready, if32.busy, if32.load_state, if32.sel_iv, if32.round_valid,
                 if32.final_add, if32.done, if32.round_idx};
    a_w[0]    = if64.w_out;
    a_w[1]    = {32'h0, if32.w_out};
    a_st[0]   = if64.dbg_state;
    a_st[1]   = if32.dbg_state;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full message schedule W0..W79, textbook recurrence on an array.
  function automatic sched_t calc_sched(input logic [1023:0] m, input logic md);
    sched_t s;
    logic [31:0] a, b;
    for (int t = 0; t < 16; t++) begin
      s[t] = m[(16-t)*64-1 -: 64];
      if (!md) s[t][63:32] = 32'h0;
    end
    for (int t = 16; t < 80; t++) begin
      if (md) begin
        s[t] = (rr64(s[t-2], 19) ^ rr64(s[t-2], 61) ^ (s[t-2] >> 6)) + s[t-7]
             + (rr64(s[t-15], 1) ^ rr64(s[t-15], 8) ^ (s[t-15] >> 7)) + s[t-16];
      end else begin
        a = s[t-2][31:0];
        b = s[t-15][31:0];
        s[t] = {32'h0, (rr32(a, 17) ^ rr32(a, 19) ^ (a >> 10)) + s[t-7][31:0]
                     + (rr32(b, 7) ^ rr32(b, 18) ^ (b >> 3)) + s[t-16][31:0]};
      end
    end
    return s;
  endfunction

  // Per lane: m_ph = -1 when idle, else cycles elapsed since the accept edge.
  int          m_ph   [2] = '{-1, -1};
  int          m_last [2] = '{63, 63};
  logic        m_first[2];
  logic [63:0] m_s    [2][80];

  always @(posedge clk or posedge rst) begin
    sched_t tmp;
    logic   me;
    if (rst) begin
      for (int l = 0; l < 2; l++) m_ph[l] <= -1;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (m_ph[l] < 0) begin
          if (start) begin
            me = (l == 0) ? mode_512 : 1'b0;
            tmp = calc_sched(msg, me);
            m_ph[l]    <= 1;
            m_first[l] <= first_block;
            m_last[l]  <= me ? 79 : 63;
            for (int j = 0; j < 80; j++) m_s[l][j] <= tmp[j];
          end
        end else if (abort || m_ph[l] == m_last[l] + 4) begin
          m_ph[l] <= -1;
        end else begin
          m_ph[l] <= m_ph[l] + 1;
        end
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    int          ph;
    int          lst;
    logic        rv;
    logic [13:0] e_ctrl;
    logic [63:0] e_w;
    for (int l = 0; l < 2; l++) begin
      ph  = m_ph[l];
      lst = m_last[l];
      rv  = (ph >= 2) && (ph <= lst + 2);
      e_ctrl = {ph < 0, (ph >= 1) && (ph <= lst + 3), ph == 1, (ph == 1) && m_first[l], rv,
                ph == lst + 3, ph == lst + 4, rv ? 7'(ph - 2) : 7'd0};
      e_w = 64'h0;
      if (rv) e_w = m_s[l][ph-2];
      checks++;
      if (a_ctrl[l] !== e_ctrl) begin
        errors++;
        $display("FAIL lane%0d ctrl @%0t got %b want %b (dbg_state %0d)",
                 l, $time, a_ctrl[l], e_ctrl, a_st[l]);
      end
      checks++;
      if (a_w[l] !== e_w) begin
        errors++;
        $display("FAIL lane%0d w_out @%0t got %h want %h", l, $time, a_w[l], e_w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic go(input int k);
    while (off < k) begin
      @(negedge clk);
      off++;
    end
  endtask

  task automatic launch(input logic [1023:0] m, input logic md, input logic fb);
    @(negedge clk);
    msg = m;
    mode_512 = md;
    first_block = fb;
    start = 1'b1;
    off = 0;
  endtask

  function automatic logic [1023:0] rand_msg();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  logic [1023:0] abc256, abc512;
  sched_t        pin;

  // ---------------- directed stimulus ----------------
  initial begin
    abc256 = '0;
    abc256[1023 -: 64] = 64'h0000_0000_6162_6380;
    abc256[63:0] = 64'h18;
    abc512 = '0;
    abc512[1023 -: 64] = 64'h6162_6380_0000_0000;
    abc512[63:0] = 64'h18;

    // Model pins against hand-computed schedule words.
    pin = calc_sched(abc256, 1'b0);
    chk("model_w16_256", pin[16], 64'h6162_6380);
    chk("model_w17_256", pin[17], 64'h000F_0000);
    pin = calc_sched(abc512, 1'b1);
    chk("model_w16_512", pin[16], 64'h6162_6380_0000_0000);
    chk("model_w17_512", pin[17], 64'h0003_0000_0000_00C0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ctrl64", 64'(a_ctrl[0]), 64'(RESET_CTRL));
    chk("rst_ctrl32", 64'(a_ctrl[1]), 64'(RESET_CTRL));
    chk("rst_w64", a_w[0], 64'h0);
    rst = 1'b0;

    // SHA-256 "abc".
    launch(abc256, 1'b0, 1'b1);
    go(1); start = 1'b0;
    chk("abc256_sel_iv", 64'(a_ctrl[0][B_SEL]), 64'h1);
    chk("abc256_load", 64'(a_ctrl[0][B_LOAD]), 64'h1);
    go(2);  chk("abc256_idx0", 64'(a_ctrl[0][6:0]), 64'd0);
    go(18); chk("abc256_w16", a_w[0], 64'h6162_6380);
    go(19); chk("abc256_w17", a_w[0], 64'h000F_0000);
    go(65); chk("abc256_idx63", 64'(a_ctrl[0][6:0]), 64'd63);
    go(66); chk("abc256_final", 64'(a_ctrl[0][B_FINAL]), 64'h1);
            chk("abc256_no_done66", 64'(a_ctrl[0][B_DONE]), 64'h0);
    go(67); chk("abc256_done67", 64'(a_ctrl[0][B_DONE]), 64'h1);
    go(68); chk("abc256_ready68", 64'(a_ctrl[0][B_READY]), 64'h1);

    // SHA-512 "abc"; the 32-bit instance runs it as SHA-256.
    launch(abc512, 1'b1, 1'b1);
    go(1); start = 1'b0;
    go(18); chk("abc512_w16", a_w[0], 64'h6162_6380_0000_0000);
    go(19); chk("abc512_w17", a_w[0], 64'h0003_0000_0000_00C0);
    go(67); chk("abc512_lane32_done67", 64'(a_ctrl[1][B_DONE]), 64'h1);
            chk("abc512_lane64_busy67", 64'(a_ctrl[0][B_BUSY]), 64'h1);
    go(81); chk("abc512_idx79", 64'(a_ctrl[0][6:0]), 64'd79);
    go(83); chk("abc512_done83", 64'(a_ctrl[0][B_DONE]), 64'h1);
    go(84); chk("abc512_ready84", 64'(a_ctrl[0][B_READY]), 64'h1);

    // start held high: second accept at n+68 from the running hash.
    launch(rand_msg(), 1'b0, 1'b1);
    go(1); first_block = 1'b0; msg = rand_msg();
    go(67); chk("b2b_done67", 64'(a_ctrl[0][B_DONE]), 64'h1);
    go(68); chk("b2b_ready68", 64'(a_ctrl[0][B_READY]), 64'h1);
    go(69); start = 1'b0;
    chk("b2b_load69", 64'(a_ctrl[0][B_LOAD]), 64'h1);
    chk("b2b_sel_iv0", 64'(a_ctrl[0][B_SEL]), 64'h0);
    go(68 + 67); chk("b2b_done2", 64'(a_ctrl[0][B_DONE]), 64'h1);
    go(68 + 69);

    // start pulsed mid-round is ignored; abort at t=10.
    launch(rand_msg(), 1'b1, 1'b0);
    go(1); start = 1'b0;
    go(5); start = 1'b1; msg = rand_msg(); mode_512 = 1'b0;
    go(6); start = 1'b0;
    go(12); chk("abort_idx10", 64'(a_ctrl[0][6:0]), 64'd10);
    abort = 1'b1;
    go(13); abort = 1'b0;
    chk("abort_ready64", 64'(a_ctrl[0][B_READY]), 64'h1);
    chk("abort_ready32", 64'(a_ctrl[1][B_READY]), 64'h1);
    chk("abort_busy64", 64'(a_ctrl[0][B_BUSY]), 64'h0);
    go(100);

    // Asynchronous reset at t=30, then a clean block right after release.
    launch(rand_msg(), 1'b0, 1'b1);
    go(1); start = 1'b0;
    go(32);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl64", 64'(a_ctrl[0]), 64'(RESET_CTRL));
    chk("midrst_ctrl32", 64'(a_ctrl[1]), 64'(RESET_CTRL));
    chk("midrst_w64", a_w[0], 64'h0);
    chk("midrst_w32", a_w[1], 64'h0);
    go(34); rst = 1'b0;
    launch(rand_msg(), 1'b1, 1'b1);
    go(1); start = 1'b0;
    go(83); chk("postrst_done83", 64'(a_ctrl[0][B_DONE]), 64'h1);
    go(85);

    // abort alone in IDLE does nothing; start+abort together is accepted.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_abort_ready", 64'(a_ctrl[0][B_READY]), 64'h1);
    launch(abc256, 1'b1, 1'b1);
    go(1); start = 1'b0; abort = 1'b0;
    chk("start_abort_load", 64'(a_ctrl[1][B_LOAD]), 64'h1);
    go(18); chk("w32_w16", a_w[1], 64'h6162_6380);
    go(19); chk("w32_w17", a_w[1], 64'h000F_0000);
    go(66); chk("w32_no_done66", 64'(a_ctrl[1][B_DONE]), 64'h0);
    go(67); chk("w32_done67", 64'(a_ctrl[1][B_DONE]), 64'h1);
    go(85);

    // A few random blocks for broader schedule coverage.
    for (int i = 0; i < 3; i++) begin
      launch(rand_msg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      go(1); start = 1'b0;
      go(86);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
